qbu_verify_rx: RTL

- Receive-side companion of the Qbu verify/response mPacket generator in switch_core/txmac/qbu_tx.
- Sits in the RX MAC after preamble strip and SMD extraction.
- Checks incoming SMD-V (0x07) and SMD-R (0x19) mPackets for length, all-zero payload and optional mCRC.
- Emits one-cycle received-verify / received-response pulses that drive the local verify state machine, plus statistics counters.

---
 rtl/qbu_verify_rx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/qbu_verify_rx.sv
// Qbu verify/response mPacket receiver: checks SMD-V / SMD-R frames for length,
// all-zero payload and optional mCRC, then reports them as pulses and counters.
module qbu_verify_rx #(
  parameter int AXIS_DATA_WIDTH = 8,
  parameter int PAYLOAD_LEN     = 60,
  parameter bit MCRC_EN         = 1'b0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [AXIS_DATA_WIDTH-1:0] i_rx_data,
  input  logic                       i_rx_valid,
  input  logic                       i_rx_last,
  output logic                       o_rx_ready,
  input  logic [7:0]                 i_rx_smd,
  input  logic                       i_rx_smd_valid,
  input  logic                       i_verify_enabled,
  output logic                       o_qbu_verify_valid,
  output logic                       o_qbu_response_valid,
  output logic [15:0]                o_rx_verify_cnt,
  output logic [15:0]                o_rx_response_cnt,
  output logic [15:0]                o_rx_err_cnt,
  output logic [1:0]                 o_fsm_state
);

  // Handshake: a beat transfers on any cycle with i_rx_valid && o_rx_ready;
  // ready drops only for the single CHECK cycle after a frame's last beat.

  localparam logic [15:0] FRAME_LEN = 16'(PAYLOAD_LEN + (MCRC_EN ? 4 : 0));
  localparam logic [15:0] PAY_LEN   = 16'(PAYLOAD_LEN);
  localparam logic [7:0]  SMD_V     = 8'h07;
  localparam logic [7:0]  SMD_R     = 8'h19;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_DROP  = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        ready;
  logic        beat;
  logic [7:0]  octet;
  logic        smd_match;
  logic        start, accum;
  logic        err_inc, ver_inc, resp_inc;
  logic        is_resp;
  logic [15:0] byte_cnt;
  logic        zero_ok;
  logic [31:0] crc;
  logic [31:0] cap;
  logic [31:0] mcrc;
  logic        frame_good;
  logic [15:0] verify_cnt, response_cnt, err_cnt;
  logic        verify_pulse, response_pulse;

  // Reflected CRC-32 (poly 0xEDB88320), one octet per call, LSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign octet      = i_rx_data[7:0];
  assign beat       = i_rx_valid && ready;
  assign smd_match  = (i_rx_smd == SMD_V) || (i_rx_smd == SMD_R);
  assign mcrc       = ~crc ^ 32'h0000_FFFF;
  assign frame_good = (byte_cnt == FRAME_LEN) && zero_ok && (!MCRC_EN || (mcrc == cap));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt != S_CHECK);
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    accum     = 1'b0;
    err_inc   = 1'b0;
    ver_inc   = 1'b0;
    resp_inc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (beat) begin
          if (i_rx_smd_valid && smd_match && i_verify_enabled) begin
            start     = 1'b1;
            state_nxt = i_rx_last ? S_CHECK : S_RECV;
          end else if (!i_rx_last) begin
            state_nxt = S_DROP;
          end
        end
      end
      S_RECV: begin
        if (beat) begin
          accum = 1'b1;
          if (i_rx_last) begin
            state_nxt = S_CHECK;
          end else if (byte_cnt + 16'd1 == FRAME_LEN) begin
            // Full length reached with no last: overlength, swallow the rest.
            state_nxt = S_DROP;
            err_inc   = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (beat && i_rx_last) state_nxt = S_IDLE;
      end
      S_CHECK: begin
        state_nxt = S_IDLE;
        if (frame_good) begin
          ver_inc  = !is_resp;
          resp_inc = is_resp;
        end else begin
          err_inc = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      is_resp  <= 1'b0;
      byte_cnt <= '0;
      zero_ok  <= 1'b0;
      crc      <= '0;
      cap      <= '0;
    end else if (start) begin
      is_resp  <= (i_rx_smd == SMD_R);
      byte_cnt <= 16'd1;
      zero_ok  <= (octet == 8'h00);
      crc      <= crc_step(32'hFFFF_FFFF, octet);
      cap      <= '0;
    end else if (accum) begin
      byte_cnt <= byte_cnt + 16'd1;
      if (byte_cnt < PAY_LEN) begin
        zero_ok <= zero_ok && (octet == 8'h00);
        crc     <= crc_step(crc, octet);
      end else begin
        // mCRC arrives LS octet first; shift in from the top.
        cap <= {octet, cap[31:8]};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      verify_pulse   <= 1'b0;
      response_pulse <= 1'b0;
      verify_cnt     <= '0;
      response_cnt   <= '0;
      err_cnt        <= '0;
    end else begin
      verify_pulse   <= ver_inc;
      response_pulse <= resp_inc;
      if (ver_inc && (verify_cnt != 16'hFFFF))    verify_cnt   <= verify_cnt + 16'd1;
      if (resp_inc && (response_cnt != 16'hFFFF)) response_cnt <= response_cnt + 16'd1;
      if (err_inc && (err_cnt != 16'hFFFF))       err_cnt      <= err_cnt + 16'd1;
    end
  end

  assign o_rx_ready           = ready;
  assign o_qbu_verify_valid   = verify_pulse;
  assign o_qbu_response_valid = response_pulse;
  assign o_rx_verify_cnt      = verify_cnt;
  assign o_rx_response_cnt    = response_cnt;
  assign o_rx_err_cnt         = err_cnt;
  assign o_fsm_state          = state;

endmodule
